// File: rtl/da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic front end.
package da_pkg;

  localparam int DA_TAPS   = 3;
  localparam int LUT_W     = 3;
  localparam int DEFAULT_B = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

endpackage

// File: rtl/da_serial_acc.sv
// Serializes three samples LSB first into an external DA coefficient LUT
// and shift-accumulates the returned partial sums into y = 2*x0 + 3*x1 + x2.
module da_serial_acc
  import da_pkg::*;
#(
  parameter int B         = DEFAULT_B,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [B-1:0]       x0,
  input  logic [B-1:0]       x1,
  input  logic [B-1:0]       x2,
  output logic [DA_TAPS-1:0] table_in,
  input  logic [LUT_W-1:0]   table_out,
  output logic [B+2:0]       y,
  output logic               out_valid
);

  localparam int CW = $clog2(B);

  state_t        state;
  logic [B-1:0]  sr0, sr1, sr2;
  logic [CW-1:0] cnt;
  logic [B+2:0]  acc;
  logic [B+2:0]  p;
  logic [B+2:0]  acc_next;
  logic          last_bit;

  assign in_ready = (state == IDLE);

  // Shift registers are empty whenever the block is idle, so the address is
  // taken straight from flops and reads zero outside SHIFT.
  assign table_in = {sr2[0], sr1[0], sr0[0]};

  always_comb begin
    last_bit = (state == SHIFT) && (cnt == CW'(B - 1));
    p        = (B + 3)'(table_out) << cnt;
    if (SIGNED_IN && last_bit) begin
      acc_next = acc - p;
    end else begin
      acc_next = acc + p;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr0       <= '0;
      sr1       <= '0;
      sr2       <= '0;
      cnt       <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          sr0   <= x0;
          sr1   <= x1;
          sr2   <= x2;
          acc   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
      end else begin
        acc <= acc_next;
        sr0 <= sr0 >> 1;
        sr1 <= sr1 >> 1;
        sr2 <= sr2 >> 1;
        cnt <= cnt + CW'(1);
        if (last_bit) begin
          y         <= acc_next;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_da_serial_acc.sv
// Scoreboard bench: an unsigned and a signed instance share one stimulus
// stream; each talks to its own copy of the (2,3,1) coefficient LUT.
module tb_da_serial_acc;

  localparam int B  = 8;
  localparam int YW = B + 3;

  typedef struct {
    logic [YW-1:0] y;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [B-1:0]  x0, x1, x2;
  logic [1:0]    in_ready, out_valid;
  logic [2:0]    table_in_u, table_in_s, table_out_u, table_out_s;
  logic [YW-1:0] y_u, y_s;

  exp_t       q_u[$];
  exp_t       q_s[$];
  logic [2:0] col_q[$];
  int         total = 0;
  int         bad = 0;
  int         cycle_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  function automatic logic [2:0] coeff_lut(input logic [2:0] a);
    int s;
    s = 0;
    if (a[0]) s += 2;
    if (a[1]) s += 3;
    if (a[2]) s += 1;
    return 3'(s);
  endfunction

  assign table_out_u = coeff_lut(table_in_u);
  assign table_out_s = coeff_lut(table_in_s);

  da_serial_acc #(.B(B), .SIGNED_IN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .x0(x0), .x1(x1), .x2(x2), .table_in(table_in_u), .table_out(table_out_u),
    .y(y_u), .out_valid(out_valid[0])
  );

  da_serial_acc #(.B(B), .SIGNED_IN(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .x0(x0), .x1(x1), .x2(x2), .table_in(table_in_s), .table_out(table_out_s),
    .y(y_s), .out_valid(out_valid[1])
  );

  function automatic logic [YW-1:0] ref_model(input logic [B-1:0] a, b, c, input bit sgn);
    int va, vb, vc;
    if (sgn) begin
      va = int'($signed(a));
      vb = int'($signed(b));
      vc = int'($signed(c));
    end else begin
      va = int'(a);
      vb = int'(b);
      vc = int'(c);
    end
    return YW'(2 * va + 3 * vb + vc);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called on the negedge just before the accepting edge.
  task automatic push_expected(input logic [B-1:0] a, b, c);
    exp_t e;
    e.cyc = cycle_count + 1;
    e.y   = ref_model(a, b, c, 1'b0);
    q_u.push_back(e);
    e.y   = ref_model(a, b, c, 1'b1);
    q_s.push_back(e);
    for (int k = 0; k < B; k++) col_q.push_back({c[k], b[k], a[k]});
  endtask

  task automatic applyStimulus(input logic [B-1:0] a, b, c);
    bit accepted;
    accepted = 1'b0;
    x0 = a; x1 = b; x2 = c;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        push_expected(a, b, c);
        accepted = 1'b1;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] c;
    if (!reset) begin
      if (out_valid[0]) begin
        if (q_u.size() == 0) checkOutput("stray_out_valid_u", 1, 0);
        else begin
          e = q_u.pop_front();
          checkOutput("y_unsigned", 32'(y_u), 32'(e.y));
          checkOutput("latency_unsigned", cycle_count - e.cyc, B);
        end
      end
      if (out_valid[1]) begin
        if (q_s.size() == 0) checkOutput("stray_out_valid_s", 1, 0);
        else begin
          e = q_s.pop_front();
          checkOutput("y_signed", 32'(y_s), 32'(e.y));
          checkOutput("latency_signed", cycle_count - e.cyc, B);
        end
      end
      if (!in_ready[0]) begin
        if (col_q.size() == 0) checkOutput("stray_busy", 1, 0);
        else begin
          c = col_q.pop_front();
          checkOutput("table_in_u", 32'(table_in_u), 32'(c));
          checkOutput("table_in_s", 32'(table_in_s), 32'(c));
          checkOutput("in_ready_s_busy", 32'(in_ready[1]), 0);
        end
      end
    end
  end

  task automatic check_idle_state(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 3);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_y_u"}, 32'(y_u), 0);
    checkOutput({tag, "_y_s"}, 32'(y_s), 0);
    checkOutput({tag, "_table_in"}, {26'd0, table_in_s, table_in_u}, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; x0 = '0; x1 = '0; x2 = '0;
    repeat (2) @(posedge clk);
    #1 check_idle_state("reset");
    reset = 1'b0;

    // Directed cases; consecutive calls also exercise back-to-back accepts.
    applyStimulus(8'd1, 8'd1, 8'd1);
    applyStimulus(8'd255, 8'd255, 8'd255);
    applyStimulus(8'd10, 8'd0, 8'd7);
    applyStimulus(8'hFF, 8'd0, 8'd0);
    applyStimulus(8'h80, 8'h80, 8'h80);
    applyStimulus(8'd127, 8'hFF, 8'd3);
    for (int i = 0; i < 12; i++)
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom));

    // in_valid held high while data changes every cycle.
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
      @(negedge clk);
      if (in_ready[0]) push_expected(x0, x1, x2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Abort mid-operation at cnt = 4.
    applyStimulus(8'd200, 8'd100, 8'd50);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    q_u.delete(); q_s.delete(); col_q.delete();
    reset = 1'b0;
    check_idle_state("midreset");
    repeat (12) @(posedge clk);
    #1;
    applyStimulus(8'd33, 8'd200, 8'd129);
    applyStimulus(8'd0, 8'd0, 8'd0);

    for (int i = 0; i < 100 && (q_u.size() + q_s.size() + col_q.size()) != 0; i++)
      @(posedge clk);
    #1 checkOutput("drain", q_u.size() + q_s.size() + col_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
